dummy_mc_model: RTL and testbench
=================================

// Module: dummy_mc_model
// PURPOSE
//  Behavioural single-port memory-controller stand-in for the PDES engine (phold) in simulation.
//  Accepts Convey-style MC requests (read/write/flush) and returns responses with fixed latency.
//  Backed by an internal 64-bit-word RAM; responses carry the requester's rtnctl tag unchanged.
//  Responses are queued and drained under core back-pressure.
// PARAMETERS
//  MC_RTNCTL_WIDTH  32   width of rtnctl tag passed request->response
//  RAM_DEPTH        512  number of 64-bit words (power of two)
//  LATENCY          4    cycles from request acceptance to FIFO entry (>=1)
//  FIFO_DEPTH       16   response FIFO entries (power of two, > LATENCY+2)
// PORTS
//  clk           in   1    clock, all logic on rising edge
//  rst_n         in   1    reset, asynchronous, active-low
//  mc_rq_vld     in   1    request valid
//  mc_rq_cmd     in   3    1=READ, 2=WRITE, others ignored
//  mc_rq_scmd    in   4    subcommand, echoed on response
//  mc_rq_vadr    in   48   byte address
//  mc_rq_size    in   2    access size (all treated as 8-byte)
//  mc_rq_rtnctl  in   RW   return tag
//  mc_rq_data    in   64   write data
//  mc_rq_flush   in   1    flush request
//  mc_rq_stall   out  1    requester must stop issuing
//  mc_rs_vld     out  1    response valid (1-cycle per response)
//  mc_rs_cmd     out  3    2=READ_DATA, 3=WRITE_COMPLETE, 7=FLUSH_COMPLETE
//  mc_rs_scmd    out  4    echoed scmd (0 for flush)
//  mc_rs_rtnctl  out  RW   echoed rtnctl (0 for flush)
//  mc_rs_data    out  64   read data (0 for write/flush)
//  mc_rs_stall   in   1    core back-pressure on responses
// BEHAVIOUR
//  - Reset (rst_n=0): all outputs 0, FIFO empty, latency pipe cleared; RAM contents untouched.
//  - RAM powers up all-zero; word index = vadr[3 +: log2(RAM_DEPTH)]; upper bits ignored (wrap).
//  - Acceptance: request accepted every cycle mc_rq_vld=1 (stall is advisory; requests in the
//    2 cycles after stall asserts must still be accepted without loss).
//  - WRITE: RAM updated at acceptance edge; response WRITE_COMPLETE.
//  - READ: RAM sampled at acceptance edge (sees writes accepted in earlier cycles); READ_DATA.
//  - mc_rq_flush=1 (with or without vld): one FLUSH_COMPLETE entered after all prior requests.
//    Same cycle as a valid request: request's response first, flush next cycle of the pipe.
//  - Unknown cmd with vld: no RAM effect, no response.
//  - Pipe: accepted response enters FIFO exactly LATENCY cycles after acceptance; order preserved.
//  - Drain: each edge, if FIFO non-empty and mc_rs_stall=0, pop and drive registered mc_rs_* with
//    mc_rs_vld=1; otherwise mc_rs_vld=0 (other rs fields hold last value). Min latency LATENCY+1.
//  - mc_rq_stall (registered) = 1 when FIFO count + in-flight >= FIFO_DEPTH-2, else 0.
//  - Simultaneous push and pop in one cycle allowed; count unchanged.
//  - FIFO overflow is a bench error: assertion fires, entry dropped.
//  - Reset mid-operation discards in-flight and queued responses; no spurious rs_vld after.
// STRUCTURE
//  - Package mc_pkg: MC_CMD_RD=3'd1, MC_CMD_WR=3'd2, MC_RS_RDDATA=3'd2, MC_RS_WRCMP=3'd3,
//    MC_RS_FLCMP=3'd7; response struct {cmd,scmd,rtnctl,data}.
//  - One sub-module: mc_rsp_fifo (synchronous FIFO, count output, async active-low reset).
//  - Top holds RAM array, LATENCY-deep shift register of response structs, stall logic.
// TESTING
//  - WR vadr=0x10 data=0xDEADBEEF rtnctl=5, then RD vadr=0x10 rtnctl=6 -> WRCMP tag5, then
//    RDDATA tag6 data 0xDEADBEEF, each LATENCY+1 cycles after issue.
//  - RD vadr=0x10+8*512 -> aliases word 2, returns 0xDEADBEEF (wrap).
//  - mc_rs_stall=1 while 20 back-to-back RDs issued -> mc_rq_stall asserts, no loss; release ->
//    all responses returned in order with consecutive rs_vld.
//  - Flush after 3 writes -> 3 WRCMP then FLCMP (rtnctl 0).
//  - cmd=3'd5 with vld -> no response, RAM unchanged.
//  - rst_n low with 4 requests in flight -> outputs 0, no responses after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared command/response encodings and the response record carried through
// the latency pipe and response FIFO of the memory-controller stand-in.
package mc_pkg;

    localparam logic [2:0] MC_CMD_RD    = 3'd1;
    localparam logic [2:0] MC_CMD_WR    = 3'd2;
    localparam logic [2:0] MC_RS_RDDATA = 3'd2;
    localparam logic [2:0] MC_RS_WRCMP  = 3'd3;
    localparam logic [2:0] MC_RS_FLCMP  = 3'd7;

    // Stored tag width; wider requester tags are truncated to this.
    localparam int MC_RTNCTL_W = 32;

    typedef struct packed {
        logic [2:0]             cmd;
        logic [3:0]             scmd;
        logic [MC_RTNCTL_W-1:0] rtnctl;
        logic [63:0]            data;
    } mc_rsp_t;

    // One pipe slot: an optional request response plus an optional flush behind it.
    typedef struct packed {
        logic    rq;
        logic    fl;
        mc_rsp_t rsp;
    } mc_pipe_t;

    function automatic mc_rsp_t mc_flush_rsp();
        mc_rsp_t r;
        r        = '0;
        r.cmd    = MC_RS_FLCMP;
        return r;
    endfunction

endpackage

// File: rtl/mc_rsp_fifo.sv
// In-order response FIFO with two ordered push ports (a before b), one pop port
// and an occupancy count. Entries that do not fit are dropped and flagged.
module mc_rsp_fifo
    import mc_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_a,
    input  mc_rsp_t       data_a,
    input  logic          push_b,
    input  mc_rsp_t       data_b,
    input  logic          pop,
    output mc_rsp_t       head,
    output logic [CW-1:0] count
);

    mc_rsp_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW:0]   room;
    logic          pop_ok;
    logic          wr_a;
    logic          wr_b;

    // A pop in the same cycle frees a slot for this cycle's pushes.
    always_comb begin
        pop_ok = pop && (count != '0);
        room   = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop_ok);
        wr_a   = push_a && (room != '0);
        wr_b   = push_b && (room > (CW+1)'(wr_a));
    end

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_a) mem[wr_ptr] <= data_a;
        if (wr_b) mem[wr_ptr + AW'(wr_a)] <= data_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_a) + AW'(wr_b);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            count  <= count + CW'(wr_a) + CW'(wr_b) - CW'(pop_ok);
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
        (push_a -> wr_a) && (push_b -> wr_b))
        else $error("mc_rsp_fifo overflow: response dropped");

endmodule

// File: rtl/dummy_mc_model.sv
// Fixed-latency memory-controller stand-in: RAM-backed read/write/flush with an
// in-order response FIFO drained under core back-pressure.
module dummy_mc_model
    import mc_pkg::*;
#(
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int RAM_DEPTH       = 512,
    parameter int LATENCY         = 4,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mc_rq_vld,
    input  logic [2:0]                 mc_rq_cmd,
    input  logic [3:0]                 mc_rq_scmd,
    input  logic [47:0]                mc_rq_vadr,
    input  logic [1:0]                 mc_rq_size,
    input  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    input  logic [63:0]                mc_rq_data,
    input  logic                       mc_rq_flush,
    output logic                       mc_rq_stall,
    output logic                       mc_rs_vld,
    output logic [2:0]                 mc_rs_cmd,
    output logic [3:0]                 mc_rs_scmd,
    output logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    output logic [63:0]                mc_rs_data,
    input  logic                       mc_rs_stall
);

    localparam int IW = $clog2(RAM_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [63:0]   ram [RAM_DEPTH] = '{default: '0};
    logic [IW-1:0] idx;
    logic          is_rd;
    logic          is_wr;
    mc_pipe_t      stage_in;
    mc_pipe_t      pipe_q [LATENCY];
    mc_pipe_t      pipe_out;
    mc_rsp_t       fl_rsp;
    logic          fl_carry;
    logic          fl_carry_d;
    logic          push_a;
    logic          push_b;
    mc_rsp_t       data_a;
    mc_rsp_t       data_b;
    logic          pop;
    mc_rsp_t       head;
    logic [CW-1:0] fifo_count;
    logic [31:0]   pending;
    logic          unused_bits;

    // Handshake: requests have no ready -- every mc_rq_vld cycle is accepted and
    // mc_rq_stall is only advice to stop; each response is a one-cycle mc_rs_vld
    // pulse, and mc_rs_stall=1 keeps responses parked in the FIFO.
    assign idx         = mc_rq_vadr[3 +: IW];
    assign is_rd       = mc_rq_vld && (mc_rq_cmd == MC_CMD_RD);
    assign is_wr       = mc_rq_vld && (mc_rq_cmd == MC_CMD_WR);
    assign unused_bits = ^{mc_rq_size, mc_rq_vadr[2:0], mc_rq_vadr[47:3+IW]};
    assign fl_rsp      = mc_flush_rsp();
    assign pipe_out    = pipe_q[LATENCY-1];
    assign pop         = (fifo_count != '0) && !mc_rs_stall;

    always_comb begin
        stage_in            = '0;
        stage_in.rq         = is_rd || is_wr;
        stage_in.fl         = mc_rq_flush;
        stage_in.rsp.cmd    = is_rd ? MC_RS_RDDATA : MC_RS_WRCMP;
        stage_in.rsp.scmd   = mc_rq_scmd;
        stage_in.rsp.rtnctl = MC_RTNCTL_W'(mc_rq_rtnctl);
        stage_in.rsp.data   = is_rd ? ram[idx] : 64'd0;
    end

    always_ff @(posedge clk) begin
        if (is_wr) ram[idx] <= mc_rq_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
            fl_carry <= 1'b0;
        end else begin
            pipe_q[0] <= stage_in;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            fl_carry <= fl_carry_d;
        end
    end

    // A flush sharing a slot with a request enters the FIFO one cycle later,
    // ahead of whatever the pipe delivers in that next cycle.
    always_comb begin
        push_a     = 1'b0;
        push_b     = 1'b0;
        data_a     = pipe_out.rsp;
        data_b     = pipe_out.rsp;
        fl_carry_d = pipe_out.rq && pipe_out.fl;
        if (fl_carry) begin
            push_a = 1'b1;
            data_a = fl_rsp;
            push_b = pipe_out.rq || pipe_out.fl;
            data_b = pipe_out.rq ? pipe_out.rsp : fl_rsp;
        end else begin
            push_a = pipe_out.rq || pipe_out.fl;
            data_a = pipe_out.rq ? pipe_out.rsp : fl_rsp;
        end
    end

    always_comb begin
        pending = 32'(fl_carry);
        for (int i = 0; i < LATENCY; i++)
            pending = pending + 32'(pipe_q[i].rq) + 32'(pipe_q[i].fl);
    end

    mc_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_a (push_a),
        .data_a (data_a),
        .push_b (push_b),
        .data_b (data_b),
        .pop    (pop),
        .head   (head),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_rq_stall  <= 1'b0;
            mc_rs_vld    <= 1'b0;
            mc_rs_cmd    <= '0;
            mc_rs_scmd   <= '0;
            mc_rs_rtnctl <= '0;
            mc_rs_data   <= '0;
        end else begin
            mc_rq_stall <= (32'(fifo_count) + pending) >= 32'(FIFO_DEPTH - 2);
            mc_rs_vld   <= pop;
            if (pop) begin
                mc_rs_cmd    <= head.cmd;
                mc_rs_scmd   <= head.scmd;
                mc_rs_rtnctl <= MC_RTNCTL_WIDTH'(head.rtnctl);
                mc_rs_data   <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_dummy_mc_model.sv
// Randomized and directed bench for dummy_mc_model, checked every cycle against
// a queue-based timing model of the controller.
module tb_dummy_mc_model;

    localparam int RW         = 32;
    localparam int RAM_DEPTH  = 512;
    localparam int LATENCY    = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int EW         = 3 + 4 + RW + 64;

    logic          clk;
    logic          rst_n;
    logic          mc_rq_vld;
    logic [2:0]    mc_rq_cmd;
    logic [3:0]    mc_rq_scmd;
    logic [47:0]   mc_rq_vadr;
    logic [1:0]    mc_rq_size;
    logic [RW-1:0] mc_rq_rtnctl;
    logic [63:0]   mc_rq_data;
    logic          mc_rq_flush;
    logic          mc_rq_stall;
    logic          mc_rs_vld;
    logic [2:0]    mc_rs_cmd;
    logic [3:0]    mc_rs_scmd;
    logic [RW-1:0] mc_rs_rtnctl;
    logic [63:0]   mc_rs_data;
    logic          mc_rs_stall;

    dummy_mc_model #(
        .MC_RTNCTL_WIDTH (RW),
        .RAM_DEPTH       (RAM_DEPTH),
        .LATENCY         (LATENCY),
        .FIFO_DEPTH      (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mc_rq_vld    (mc_rq_vld),
        .mc_rq_cmd    (mc_rq_cmd),
        .mc_rq_scmd   (mc_rq_scmd),
        .mc_rq_vadr   (mc_rq_vadr),
        .mc_rq_size   (mc_rq_size),
        .mc_rq_rtnctl (mc_rq_rtnctl),
        .mc_rq_data   (mc_rq_data),
        .mc_rq_flush  (mc_rq_flush),
        .mc_rq_stall  (mc_rq_stall),
        .mc_rs_vld    (mc_rs_vld),
        .mc_rs_cmd    (mc_rs_cmd),
        .mc_rs_scmd   (mc_rs_scmd),
        .mc_rs_rtnctl (mc_rs_rtnctl),
        .mc_rs_data   (mc_rs_data),
        .mc_rs_stall  (mc_rs_stall)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0]   m_ram [RAM_DEPTH];
    logic [EW-1:0] exp_q [$];      // responses sitting in the response FIFO
    logic [EW-1:0] pend_r [$];     // responses not yet due in the FIFO
    int            pend_t [$];     // edge index at which each becomes due
    int            m_edge = 0;
    int            m_gen = 0;
    logic          exp_stall = 1'b0;
    logic          exp_vld = 1'b0;
    logic [EW-1:0] exp_last = '0;

    initial for (int i = 0; i < RAM_DEPTH; i++) m_ram[i] = 64'd0;

    function automatic logic [EW-1:0] mk(input logic [2:0] c, input logic [3:0] s,
                                         input logic [RW-1:0] t, input logic [63:0] d);
        return {c, s, t, d};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            pend_r.delete();
            pend_t.delete();
            exp_stall = 1'b0;
            exp_vld   = 1'b0;
            exp_last  = '0;
        end else begin
            int  idx;
            logic rq;
            m_edge++;
            exp_stall = (exp_q.size() + pend_t.size()) >= FIFO_DEPTH - 2;
            if (exp_q.size() > 0 && !mc_rs_stall) begin
                exp_last = exp_q.pop_front();
                exp_vld  = 1'b1;
            end else begin
                exp_vld = 1'b0;
            end
            while (pend_t.size() > 0 && pend_t[0] <= m_edge) begin
                exp_q.push_back(pend_r.pop_front());
                void'(pend_t.pop_front());
            end
            idx = int'((mc_rq_vadr >> 3) % RAM_DEPTH);
            rq  = mc_rq_vld && (mc_rq_cmd == 3'd1 || mc_rq_cmd == 3'd2);
            if (rq) begin
                if (mc_rq_cmd == 3'd1) begin
                    pend_r.push_back(mk(3'd2, mc_rq_scmd, mc_rq_rtnctl, m_ram[idx]));
                end else begin
                    pend_r.push_back(mk(3'd3, mc_rq_scmd, mc_rq_rtnctl, 64'd0));
                    m_ram[idx] = mc_rq_data;
                end
                pend_t.push_back(m_edge + LATENCY);
                m_gen++;
            end
            if (mc_rq_flush) begin
                pend_r.push_back(mk(3'd7, 4'd0, '0, 64'd0));
                pend_t.push_back(m_edge + LATENCY + (rq ? 1 : 0));
                m_gen++;
            end
        end
    end

    // ---------------- compare process + response log ----------------
    typedef struct {
        logic [2:0]    cmd;
        logic [3:0]    scmd;
        logic [RW-1:0] tag;
        logic [63:0]   data;
        int            neg;
    } obs_t;
    obs_t obs_q [$];
    int   neg_cnt = 0;

    always @(negedge clk) begin
        obs_t o;
        neg_cnt++;
        chk("rq_stall", 64'(mc_rq_stall), 64'(exp_stall));
        chk("rs_vld", 64'(mc_rs_vld), 64'(exp_vld));
        chk("rs_cmd", 64'(mc_rs_cmd), 64'(exp_last[EW-1 -: 3]));
        chk("rs_scmd", 64'(mc_rs_scmd), 64'(exp_last[EW-4 -: 4]));
        chk("rs_rtnctl", 64'(mc_rs_rtnctl), 64'(exp_last[64 +: RW]));
        chk("rs_data", mc_rs_data, exp_last[63:0]);
        if (mc_rs_vld) begin
            o.cmd  = mc_rs_cmd;
            o.scmd = mc_rs_scmd;
            o.tag  = mc_rs_rtnctl;
            o.data = mc_rs_data;
            o.neg  = neg_cnt;
            obs_q.push_back(o);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        mc_rq_vld    = 1'b0;
        mc_rq_cmd    = 3'd0;
        mc_rq_scmd   = 4'd0;
        mc_rq_vadr   = 48'd0;
        mc_rq_size   = 2'd0;
        mc_rq_rtnctl = '0;
        mc_rq_data   = 64'd0;
        mc_rq_flush  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // acc = index of the first negedge after the accepting edge
    task automatic issue(input logic vld, input logic [2:0] cmd, input logic [47:0] adr,
                         input logic [63:0] d, input logic [RW-1:0] tag, input logic fl,
                         output int acc);
        mc_rq_vld    = vld;
        mc_rq_cmd    = cmd;
        mc_rq_scmd   = 4'($urandom_range(0, 15));
        mc_rq_vadr   = adr;
        mc_rq_size   = 2'($urandom_range(0, 3));
        mc_rq_rtnctl = tag;
        mc_rq_data   = d;
        mc_rq_flush  = fl;
        @(posedge clk);
        acc = neg_cnt + 1;
        #1;
        idle_inputs();
    endtask

    task automatic chk_obs(input string name, input int i, input logic [2:0] cmd,
                           input logic [RW-1:0] tag, input logic [63:0] data);
        if (i >= obs_q.size()) begin
            chk({name, "_present"}, 64'(obs_q.size()), 64'(i + 1));
        end else begin
            chk({name, "_cmd"}, 64'(obs_q[i].cmd), 64'(cmd));
            chk({name, "_tag"}, 64'(obs_q[i].tag), 64'(tag));
            chk({name, "_data"}, obs_q[i].data, data);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0, a1, acc, guard, in_order, consec, gen_base;
        logic saw_stall, released;
        logic [47:0] adr;
        int r;

        idle_inputs();
        mc_rs_stall = 1'b0;
        rst_n = 1'b0;
        step(3);
        chk("reset_rs_vld", 64'(mc_rs_vld), 64'd0);
        chk("reset_rq_stall", 64'(mc_rq_stall), 64'd0);
        chk("reset_rs_data", mc_rs_data, 64'd0);
        chk("reset_rs_cmd", 64'(mc_rs_cmd), 64'd0);
        rst_n = 1'b1;
        step(2);

        // write then read back, fixed latency
        obs_q.delete();
        issue(1'b1, 3'd2, 48'h10, 64'hDEADBEEF, 32'd5, 1'b0, a0);
        issue(1'b1, 3'd1, 48'h10, 64'd0, 32'd6, 1'b0, a1);
        step(10);
        chk("wr_rd_count", 64'(obs_q.size()), 64'd2);
        chk_obs("wrcmp", 0, 3'd3, 32'd5, 64'd0);
        chk_obs("rddata", 1, 3'd2, 32'd6, 64'hDEADBEEF);
        if (obs_q.size() >= 2) begin
            chk("wr_latency", 64'(obs_q[0].neg - a0), 64'(LATENCY + 1));
            chk("rd_latency", 64'(obs_q[1].neg - a1), 64'(LATENCY + 1));
        end

        // address wrap onto word 2
        obs_q.delete();
        issue(1'b1, 3'd1, 48'h10 + 48'(8 * RAM_DEPTH), 64'd0, 32'd7, 1'b0, acc);
        step(10);
        chk_obs("wrap", 0, 3'd2, 32'd7, 64'hDEADBEEF);

        // back-pressure: 20 reads, respecting mc_rq_stall
        obs_q.delete();
        mc_rs_stall = 1'b1;
        saw_stall = 1'b0;
        released = 1'b0;
        for (int i = 0; i < 20; i++) begin
            guard = 0;
            while (mc_rq_stall && guard < 200) begin
                saw_stall = 1'b1;
                if (!released) begin
                    step(3);
                    mc_rs_stall = 1'b0;
                    released = 1'b1;
                end else begin
                    step(1);
                end
                guard++;
            end
            adr = 48'($urandom_range(0, 15)) << 3;
            issue(1'b1, 3'd1, adr, 64'd0, RW'(100 + i), 1'b0, acc);
        end
        mc_rs_stall = 1'b0;
        step(40);
        chk("bp_saw_stall", 64'(saw_stall), 64'd1);
        chk("bp_count", 64'(obs_q.size()), 64'd20);
        in_order = 0;
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i].tag == RW'(100 + i)) in_order++;
        chk("bp_in_order", 64'(in_order), 64'd20);
        consec = 0;
        for (int i = 1; i < 13 && i < obs_q.size(); i++)
            if (obs_q[i].neg == obs_q[i-1].neg + 1) consec++;
        chk("bp_consecutive", 64'(consec), 64'd12);

        // flush after three writes, then flush sharing a cycle with a write
        obs_q.delete();
        issue(1'b1, 3'd2, 48'h20, 64'h11, 32'd11, 1'b0, acc);
        issue(1'b1, 3'd2, 48'h28, 64'h22, 32'd12, 1'b0, acc);
        issue(1'b1, 3'd2, 48'h30, 64'h33, 32'd13, 1'b0, acc);
        issue(1'b0, 3'd0, 48'h0, 64'd0, 32'd99, 1'b1, acc);
        step(12);
        chk("flush_count", 64'(obs_q.size()), 64'd4);
        chk_obs("flush_w0", 0, 3'd3, 32'd11, 64'd0);
        chk_obs("flush_w1", 1, 3'd3, 32'd12, 64'd0);
        chk_obs("flush_w2", 2, 3'd3, 32'd13, 64'd0);
        chk_obs("flush_cmp", 3, 3'd7, 32'd0, 64'd0);
        obs_q.delete();
        issue(1'b1, 3'd2, 48'h38, 64'h44, 32'd20, 1'b1, acc);
        issue(1'b1, 3'd1, 48'h20, 64'd0, 32'd21, 1'b0, acc);
        step(12);
        chk_obs("cof_wr", 0, 3'd3, 32'd20, 64'd0);
        chk_obs("cof_fl", 1, 3'd7, 32'd0, 64'd0);
        chk_obs("cof_rd", 2, 3'd2, 32'd21, 64'h11);

        // unknown command: no response, RAM unchanged
        obs_q.delete();
        issue(1'b1, 3'd5, 48'h10, 64'h1234, 32'd30, 1'b0, acc);
        step(10);
        chk("unk_no_rsp", 64'(obs_q.size()), 64'd0);
        issue(1'b1, 3'd1, 48'h10, 64'd0, 32'd31, 1'b0, acc);
        step(10);
        chk_obs("unk_ram", 0, 3'd2, 32'd31, 64'hDEADBEEF);

        // reset with four requests in flight
        issue(1'b1, 3'd1, 48'h10, 64'd0, 32'd40, 1'b0, acc);
        issue(1'b1, 3'd2, 48'h18, 64'h55, 32'd41, 1'b0, acc);
        issue(1'b1, 3'd1, 48'h18, 64'd0, 32'd42, 1'b0, acc);
        issue(1'b1, 3'd2, 48'h40, 64'h66, 32'd43, 1'b1, acc);
        rst_n = 1'b0;
        obs_q.delete();
        step(2);
        chk("rst_mid_vld", 64'(mc_rs_vld), 64'd0);
        chk("rst_mid_stall", 64'(mc_rq_stall), 64'd0);
        chk("rst_mid_tag", 64'(mc_rs_rtnctl), 64'd0);
        rst_n = 1'b1;
        step(12);
        chk("rst_no_rsp", 64'(obs_q.size()), 64'd0);

        // randomized traffic
        obs_q.delete();
        gen_base = m_gen;
        for (int c = 0; c < 500; c++) begin
            mc_rs_stall = ($urandom_range(0, 99) < 30);
            if (!mc_rq_stall && (exp_q.size() + pend_t.size()) < FIFO_DEPTH - 4) begin
                r = $urandom_range(0, 99);
                mc_rq_vld    = (r < 75);
                mc_rq_cmd    = (r < 35) ? 3'd1 : (r < 65) ? 3'd2 : 3'($urandom_range(3, 7));
                mc_rq_scmd   = 4'($urandom_range(0, 15));
                mc_rq_vadr   = {16'($urandom), 32'($urandom)};
                mc_rq_vadr[11:3] = 9'($urandom_range(0, 15));
                mc_rq_size   = 2'($urandom_range(0, 3));
                mc_rq_rtnctl = RW'($urandom);
                mc_rq_data   = {$urandom, $urandom};
                mc_rq_flush  = ($urandom_range(0, 99) < 8);
            end else begin
                idle_inputs();
            end
            step(1);
        end
        idle_inputs();
        mc_rs_stall = 1'b0;
        step(40);
        chk("rand_rsp_count", 64'(obs_q.size()), 64'(m_gen - gen_base));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
